// File: rtl/router_input_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_input_buffer_pkg
// Description : Shared mesh constants, packet field layout and XY route helper.
// Revision    : 1.0 - initial release
// ============================================================================
package router_input_buffer_pkg;

  localparam int PACKET_LENGTH = 16;
  localparam int MESH_SIZE     = 4;

  // Output port indices into the one-hot route vector
  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  // Coordinates are one bit wider than the mesh needs so out-of-mesh targets are encodable
  localparam int COORD_WIDTH = 3;
  localparam int DEST_X_LSB  = 0;
  localparam int DEST_Y_LSB  = 3;

  localparam logic [COORD_WIDTH:0] c_MESH_LIMIT = (COORD_WIDTH+1)'(MESH_SIZE);

  function automatic logic [4:0] xy_route(
    input logic [COORD_WIDTH-1:0] dest_x,
    input logic [COORD_WIDTH-1:0] dest_y,
    input logic [COORD_WIDTH-1:0] x,
    input logic [COORD_WIDTH-1:0] y
  );
    logic [4:0] w_route;
    w_route = '0;
    if (dest_x > x)      w_route[EAST]  = 1'b1;
    else if (dest_x < x) w_route[WEST]  = 1'b1;
    else if (dest_y > y) w_route[NORTH] = 1'b1;
    else if (dest_y < y) w_route[SOUTH] = 1'b1;
    else                 w_route[LOCAL] = 1'b1;
    return w_route;
  endfunction

  function automatic logic in_mesh(
    input logic [COORD_WIDTH-1:0] dest_x,
    input logic [COORD_WIDTH-1:0] dest_y
  );
    return ({1'b0, dest_x} < c_MESH_LIMIT) && ({1'b0, dest_y} < c_MESH_LIMIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_input_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with separate count; head output holds the
//               last popped word while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  // A full FIFO never writes, even when a pop frees a slot in the same cycle
  assign w_push = i_push && !o_full && !rst;
  assign w_pop  = i_pop && !o_empty && !rst;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : router_input_buffer
// Description : Router input port stage: packet FIFO with XY route computed at
//               enqueue and out-of-mesh packet drop.
// Revision    : 1.0 - initial release
// ============================================================================
module router_input_buffer
  import router_input_buffer_pkg::*;
#(
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PACKET_LENGTH-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_reading,
  output logic [PACKET_LENGTH-1:0]  out_data,
  output logic                      out_valid,
  output logic [4:0]                out_req,
  input  logic                      out_reading,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      err_drop
);

  localparam logic [COORD_WIDTH-1:0] c_X_POS = COORD_WIDTH'(X_COORD);
  localparam logic [COORD_WIDTH-1:0] c_Y_POS = COORD_WIDTH'(Y_COORD);

  logic [COORD_WIDTH-1:0]     w_dest_x;
  logic [COORD_WIDTH-1:0]     w_dest_y;
  logic [4:0]                 w_route;
  logic                       w_in_mesh;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [PACKET_LENGTH+4:0]   w_head;
  logic                       r_err_drop;

  assign w_dest_x  = in_data[DEST_X_LSB +: COORD_WIDTH];
  assign w_dest_y  = in_data[DEST_Y_LSB +: COORD_WIDTH];
  assign w_route   = xy_route(w_dest_x, w_dest_y, c_X_POS, c_Y_POS);
  assign w_in_mesh = in_mesh(w_dest_x, w_dest_y);

  assign in_reading = !rst && !w_full;
  assign out_valid  = !rst && !w_empty;

  // Out-of-mesh packets are still handshaken upstream, just never stored
  assign w_accept = in_valid && in_reading;
  assign w_push   = w_accept && w_in_mesh;
  assign w_pop    = out_valid && out_reading;

  sync_fifo #(
    .WIDTH (PACKET_LENGTH + 5),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({w_route, in_data}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) r_err_drop <= 1'b0;
    else     r_err_drop <= w_accept && !w_in_mesh;
  end

  assign out_data = w_head[PACKET_LENGTH-1:0];
  assign out_req  = out_valid ? w_head[PACKET_LENGTH +: 5] : 5'b0;
  assign err_drop = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_input_buffer
// Description : Scoreboard bench for router_input_buffer (4x4 mesh, node (1,1)).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_input_buffer;
  import router_input_buffer_pkg::*;

  localparam int X_C = 1;
  localparam int Y_C = 1;
  localparam int DEP = 4;

  typedef struct {
    logic [PACKET_LENGTH-1:0] data;
    logic [4:0]               req;
  } sb_entry_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [PACKET_LENGTH-1:0] in_data;
  logic                     in_valid;
  logic                     in_reading;
  logic [PACKET_LENGTH-1:0] out_data;
  logic                     out_valid;
  logic [4:0]               out_req;
  logic                     out_reading;
  logic [$clog2(DEP):0]     occupancy;
  logic                     err_drop;

  int checks = 0;
  int errors = 0;

  sb_entry_t                sb_q[$];
  logic                     exp_err = 1'b0;
  logic [PACKET_LENGTH-1:0] last_out = '0;
  int                       payload = 0;

  router_input_buffer #(.X_COORD(X_C), .Y_COORD(Y_C), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_reading(in_reading), .out_data(out_data), .out_valid(out_valid),
    .out_req(out_req), .out_reading(out_reading), .occupancy(occupancy),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // XY routing rule from coordinates, independent of any encoding in the design
  function automatic logic [4:0] ref_req(input int dx, input int dy);
    int port;
    if (dx > X_C)      port = EAST;
    else if (dx < X_C) port = WEST;
    else if (dy > Y_C) port = NORTH;
    else if (dy < Y_C) port = SOUTH;
    else               port = LOCAL;
    return 5'(1 << port);
  endfunction

  function automatic logic [PACKET_LENGTH-1:0] mkpkt(input int dx, input int dy, input int pl);
    logic [PACKET_LENGTH-1:0] p;
    p = '0;
    p[DEST_X_LSB +: COORD_WIDTH] = COORD_WIDTH'(dx);
    p[DEST_Y_LSB +: COORD_WIDTH] = COORD_WIDTH'(dy);
    p[PACKET_LENGTH-1:2*COORD_WIDTH] = (PACKET_LENGTH-2*COORD_WIDTH)'(pl);
    return p;
  endfunction

  // Monitor + reference model: check outputs mid-cycle, then apply the coming edge
  always @(negedge clk) begin
    int  dx, dy;
    bit  ready, valid;
    if (rst) begin
      chk("rst_in_reading", 32'(in_reading), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      sb_q.delete();
      exp_err  = 1'b0;
      last_out = '0;
    end else begin
      ready = (sb_q.size() != DEP);
      valid = (sb_q.size() != 0);
      chk("in_reading", 32'(in_reading), 32'(ready));
      chk("out_valid", 32'(out_valid), 32'(valid));
      chk("occupancy", 32'(occupancy), 32'(sb_q.size()));
      chk("err_drop", 32'(err_drop), 32'(exp_err));
      if (valid) begin
        chk("out_data", 32'(out_data), 32'(sb_q[0].data));
        chk("out_req", 32'(out_req), 32'(sb_q[0].req));
      end else begin
        chk("hold_data", 32'(out_data), 32'(last_out));
        chk("idle_req", 32'(out_req), 32'd0);
      end
      exp_err = 1'b0;
      if (valid && out_reading) begin
        last_out = sb_q[0].data;
        void'(sb_q.pop_front());
      end
      if (in_valid && ready) begin
        dx = int'(in_data[DEST_X_LSB +: COORD_WIDTH]);
        dy = int'(in_data[DEST_Y_LSB +: COORD_WIDTH]);
        if (dx < MESH_SIZE && dy < MESH_SIZE)
          sb_q.push_back('{data: in_data, req: ref_req(dx, dy)});
        else
          exp_err = 1'b1;
      end
    end
  end

  task automatic drive(input logic v, input logic [PACKET_LENGTH-1:0] d, input logic rd);
    in_valid    = v;
    in_data     = d;
    out_reading = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_reading = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(0, '0, 0);

    // Single packet east, then pop
    drive(1, mkpkt(3, 1, 1), 0);
    drive(0, '0, 1);
    drive(0, '0, 0);

    // Routing sweep
    drive(1, mkpkt(0, 2, 2), 0);
    drive(1, mkpkt(1, 3, 3), 0);
    drive(1, mkpkt(1, 0, 4), 0);
    drive(1, mkpkt(1, 1, 5), 0);
    repeat (5) drive(0, '0, 1);

    // Fill to full, overflow attempt, push+pop while full
    for (int i = 0; i < 5; i++) drive(1, mkpkt(2, 2, 16 + i), 0);
    drive(1, mkpkt(0, 0, 30), 1);
    drive(0, '0, 0);
    repeat (5) drive(0, '0, 1);

    // Streaming across pointer wrap
    for (int i = 0; i < 20; i++)
      drive(1, mkpkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 100 + i), 1);
    repeat (2) drive(0, '0, 1);

    // Drop then a good packet
    drive(1, mkpkt(4, 0, 200), 0);
    drive(1, mkpkt(2, 0, 201), 0);
    repeat (2) drive(0, '0, 1);

    // Reset with three packets stored
    for (int i = 0; i < 3; i++) drive(1, mkpkt(0, 3, 300 + i), 0);
    rst = 1'b1;
    drive(1, mkpkt(1, 1, 310), 1);
    rst = 1'b0;
    repeat (3) drive(0, '0, 1);

    // Randomized traffic with occasional out-of-mesh targets and rare resets
    for (int i = 0; i < 400; i++) begin
      payload = 400 + i;
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)),
            mkpkt(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), payload),
            1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    repeat (6) drive(0, '0, 1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_input_buffer.md
Name: router_input_buffer

Overview:
- Per-port input stage of the mesh router.
- Sits between a link (neighbour router or local PE) and the router crossbar/arbiter.
- Buffers incoming packets in a small FIFO and computes the XY-routing output request for each packet at enqueue.
- Drops packets addressed outside the mesh and flags the drop.

Parameters:
X_COORD, 0, column of owning router (0..MESH_SIZE-1)
Y_COORD, 0, row of owning router (0..MESH_SIZE-1)
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high; one clock, all state on rising edge of clk
in_data  input  PACKET_LENGTH  packet from upstream link
in_valid  input  1  upstream packet valid
in_reading  output  1  buffer accepts in_data this cycle
out_data  output  PACKET_LENGTH  head-of-FIFO packet to crossbar
out_valid  output  1  head entry valid
out_req  output  5  one-hot requested output port, indexed by package LOCAL/NORTH/EAST/SOUTH/WEST
out_reading  input  1  crossbar consumes head this cycle
occupancy  output  $clog2(DEPTH)+1  entries stored
err_drop  output  1  one-cycle pulse: packet discarded (destination out of mesh)

Behaviour:
- Reset: pointers and count cleared; out_valid=0, out_req=0, out_data=0, occupancy=0, err_drop=0, in_reading=1 the cycle after reset deasserts. While rst=1, in_reading=0 and out_valid=0. Reset mid-transfer discards all contents and performs no handshake that cycle.
- in_reading = (count != DEPTH); combinational from registered count only, with no dependence on in_valid or out_reading.
- Accept: in_valid && in_reading. Pop: out_valid && out_reading. out_reading while out_valid=0 is ignored.
- Full: no write, even if a pop happens the same cycle. There is no full bypass, so the upstream retries the next cycle.
- Empty: no combinational bypass. Accept-to-out_valid latency is 1 cycle.
- Simultaneous accept and pop when not full: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is separate so full and empty are unambiguous.
- Routing at accept:
  - dest_x = in_data[DEST_X_LSB +: COORD_WIDTH]; dest_y = in_data[DEST_Y_LSB +: COORD_WIDTH]; both unsigned.
  - dest_x > X_COORD -> EAST; dest_x < X_COORD -> WEST.
  - Otherwise dest_y > Y_COORD -> NORTH; dest_y < Y_COORD -> SOUTH; otherwise LOCAL.
  - The 5-bit one-hot route is stored alongside the packet. out_req is driven from the head entry, so it is register-sourced.
- Drop rule: if dest_x >= MESH_SIZE or dest_y >= MESH_SIZE, the packet is still handshaken (in_reading honoured) but not written. err_drop=1 the next cycle. Count, pointers and out_* are unaffected.
- out_req is 0 whenever out_valid=0. out_data holds its last value when empty.
- occupancy = count, registered.

Decomposition:
- my_pkg additions: COORD_WIDTH, DEST_X_LSB, DEST_Y_LSB, function xy_route(dest_x, dest_y, x, y) returning bit [4:0] one-hot.
- Existing package constants are reused: PACKET_LENGTH, MESH_SIZE, port indices.
- One sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count), instantiated with WIDTH=PACKET_LENGTH+5.
- Routing and the drop check stay in router_input_buffer.

Test Plan:
Bench config: MESH_SIZE=4, X_COORD=1, Y_COORD=1, DEPTH=4.
1. Reset then one packet dest (3,1) accepted at cycle t -> out_valid=1 at t+1, out_req=EAST one-hot, out_data equals input; out_reading at t+1 -> out_valid=0 at t+2, occupancy 0.
2. Routing sweep: dests (0,2),(1,3),(1,0),(1,1) -> out_req WEST, NORTH, SOUTH, LOCAL respectively, in order.
3. Fill: out_reading=0, 5 back-to-back in_valid -> first 4 accepted, in_reading=0 after 4th, occupancy=4. Same cycle in_valid+out_reading while full -> pop only, occupancy=3, in_reading=1 next cycle.
4. Streaming with pointer wrap: in_valid and out_reading held high for 20 cycles with incrementing payload -> 20 packets out in order, occupancy stays 1, no loss.
5. Drop: dest (4,0) accepted -> err_drop pulses 1 cycle, occupancy unchanged. A following valid packet is delivered normally.
6. Reset mid-operation: occupancy=3, assert rst one cycle -> out_valid=0, occupancy=0, the earlier packets never appear, in_reading=1 after release.
